// File: rtl/pll_mode_ctrl.sv
// Run-time supervisor for a Gowin PLLVR with dynamic IDSEL/FBDSEL/ODSEL dividers.
// Programs divider codes from a mode table, sequences PLL reset and lock, and gates the pixel reset.
module pll_mode_ctrl #(
   parameter int unsigned               NUM_MODES           = 4,
   parameter int unsigned               MODE_W              = 2,
   parameter logic [18*NUM_MODES-1:0]   MODE_TABLE          = {NUM_MODES{18'h0}},
   parameter int unsigned               INIT_MODE           = 0,
   parameter int unsigned               RESET_HOLD_CYCLES   = 16,
   parameter int unsigned               LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned               LOCK_TIMEOUT_CYCLES = 65536,
   parameter int unsigned               MAX_RETRY           = 3
) (
   input  logic              clkin,
   input  logic              rst_n,
   input  logic [MODE_W-1:0] mode_req,
   input  logic              mode_req_valid,
   output logic              mode_req_ready,
   output logic              bad_mode,
   input  logic              pll_lock,
   output logic              pll_reset,
   output logic [5:0]        idsel,
   output logic [5:0]        fbdsel,
   output logic [5:0]        odsel,
   output logic [MODE_W-1:0] cur_mode,
   output logic              locked,
   output logic              pix_rst_n,
   output logic              fail,
   output logic [1:0]        retry_cnt
);

   localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES) + 1;
   localparam int unsigned STB_W  = $clog2(LOCK_STABLE_CYCLES) + 1;
   localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [STB_W-1:0]  STABLE_MAX = STB_W'(LOCK_STABLE_CYCLES);
   localparam logic [TMO_W-1:0]  TMO_MAX    = TMO_W'(LOCK_TIMEOUT_CYCLES);
   localparam logic [17:0]       INIT_ENTRY = MODE_TABLE[18*INIT_MODE +: 18];

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_WAIT = 2'd1,
      ST_RUN  = 2'd2,
      ST_FAIL = 2'd3
   } state_e;

   // Constant-index lookup keeps out-of-range indices from selecting past the table.
   function automatic logic [17:0] table_entry(input logic [MODE_W-1:0] idx);
      logic [17:0] e;
      e = 18'h0;
      for (int unsigned i = 0; i < NUM_MODES; i++) begin
         if (32'(idx) == i) begin
            e = MODE_TABLE[18*i +: 18];
         end else begin
            e = e;
         end
      end
      return e;
   endfunction

   state_e              state_q, state_d;
   logic [1:0]          sync_q, sync_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [STB_W-1:0]    stable_cnt_q, stable_cnt_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [1:0]          retry_cnt_q, retry_cnt_d;
   logic                pll_reset_q, pll_reset_d;
   logic [5:0]          idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
   logic [MODE_W-1:0]   cur_mode_q, cur_mode_d;
   logic                locked_q, locked_d, pix_rst_n_q, pix_rst_n_d, fail_q, fail_d;
   logic                ready_q, ready_d, bad_mode_q, bad_mode_d;

   logic                lock_s, req_fire_s, req_bad_s, req_ok_s;
   logic [17:0]         req_entry_s;
   logic [STB_W-1:0]    stable_inc_s;
   logic [TMO_W-1:0]    tmo_inc_s;
   logic [1:0]          retry_inc_s;

   // Next-state and registered-output logic for the supervisor.
   always_comb begin
      sync_d       = {sync_q[0], pll_lock};
      lock_s       = sync_q[1];
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      stable_cnt_d = stable_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      retry_cnt_d  = retry_cnt_q;
      pll_reset_d  = pll_reset_q;
      idsel_d      = idsel_q;
      fbdsel_d     = fbdsel_q;
      odsel_d      = odsel_q;
      cur_mode_d   = cur_mode_q;
      locked_d     = locked_q;
      pix_rst_n_d  = pix_rst_n_q;
      fail_d       = fail_q;

      req_fire_s   = mode_req_valid && ready_q;
      req_bad_s    = req_fire_s && (32'(mode_req) >= NUM_MODES);
      req_ok_s     = req_fire_s && !req_bad_s;
      req_entry_s  = table_entry(mode_req);
      stable_inc_s = stable_cnt_q + STB_W'(1);
      tmo_inc_s    = tmo_cnt_q + TMO_W'(1);
      retry_inc_s  = (retry_cnt_q == 2'd3) ? 2'd3 : retry_cnt_q + 2'd1;
      bad_mode_d   = req_bad_s;

      // An accepted request outranks lock loss in RUN and is the only exit from FAIL.
      if (req_ok_s) begin
         state_d      = ST_HOLD;
         idsel_d      = req_entry_s[17:12];
         fbdsel_d     = req_entry_s[11:6];
         odsel_d      = req_entry_s[5:0];
         cur_mode_d   = mode_req;
         pll_reset_d  = 1'b1;
         hold_cnt_d   = '0;
         stable_cnt_d = '0;
         tmo_cnt_d    = '0;
         retry_cnt_d  = 2'd0;
         locked_d     = 1'b0;
         pix_rst_n_d  = 1'b0;
         fail_d       = 1'b0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               pll_reset_d = 1'b1;
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d      = ST_WAIT;
                  pll_reset_d  = 1'b0;
                  hold_cnt_d   = '0;
                  stable_cnt_d = '0;
                  tmo_cnt_d    = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               end
            end
            ST_WAIT: begin
               tmo_cnt_d    = tmo_inc_s;
               stable_cnt_d = lock_s ? stable_inc_s : '0;
               if (lock_s && (stable_inc_s == STABLE_MAX)) begin
                  state_d      = ST_RUN;
                  locked_d     = 1'b1;
                  pix_rst_n_d  = 1'b1;
                  stable_cnt_d = '0;
                  tmo_cnt_d    = '0;
               end else if (tmo_inc_s == TMO_MAX) begin
                  retry_cnt_d  = retry_inc_s;
                  stable_cnt_d = '0;
                  tmo_cnt_d    = '0;
                  if (32'(retry_inc_s) == MAX_RETRY) begin
                     state_d = ST_FAIL;
                     fail_d  = 1'b1;
                  end else begin
                     state_d     = ST_HOLD;
                     pll_reset_d = 1'b1;
                     hold_cnt_d  = '0;
                  end
               end else begin
                  state_d = ST_WAIT;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_d      = ST_WAIT;
                  locked_d     = 1'b0;
                  pix_rst_n_d  = 1'b0;
                  stable_cnt_d = '0;
                  tmo_cnt_d    = '0;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_FAIL: begin
               pll_reset_d = 1'b0;
               locked_d    = 1'b0;
               pix_rst_n_d = 1'b0;
               fail_d      = 1'b1;
            end
            default: begin
               state_d     = ST_HOLD;
               pll_reset_d = 1'b1;
               hold_cnt_d  = '0;
            end
         endcase
      end

      ready_d = (state_d == ST_RUN) || (state_d == ST_FAIL);
   end

   // State and output registers; reset reloads the initial mode and holds the PLL in reset.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_HOLD;
         sync_q       <= 2'b00;
         hold_cnt_q   <= '0;
         stable_cnt_q <= '0;
         tmo_cnt_q    <= '0;
         retry_cnt_q  <= 2'd0;
         pll_reset_q  <= 1'b1;
         idsel_q      <= INIT_ENTRY[17:12];
         fbdsel_q     <= INIT_ENTRY[11:6];
         odsel_q      <= INIT_ENTRY[5:0];
         cur_mode_q   <= MODE_W'(INIT_MODE);
         locked_q     <= 1'b0;
         pix_rst_n_q  <= 1'b0;
         fail_q       <= 1'b0;
         ready_q      <= 1'b0;
         bad_mode_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         hold_cnt_q   <= hold_cnt_d;
         stable_cnt_q <= stable_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         retry_cnt_q  <= retry_cnt_d;
         pll_reset_q  <= pll_reset_d;
         idsel_q      <= idsel_d;
         fbdsel_q     <= fbdsel_d;
         odsel_q      <= odsel_d;
         cur_mode_q   <= cur_mode_d;
         locked_q     <= locked_d;
         pix_rst_n_q  <= pix_rst_n_d;
         fail_q       <= fail_d;
         ready_q      <= ready_d;
         bad_mode_q   <= bad_mode_d;
      end
   end

   assign mode_req_ready = ready_q;
   assign bad_mode       = bad_mode_q;
   assign pll_reset      = pll_reset_q;
   assign idsel          = idsel_q;
   assign fbdsel         = fbdsel_q;
   assign odsel          = odsel_q;
   assign cur_mode       = cur_mode_q;
   assign locked         = locked_q;
   assign pix_rst_n      = pix_rst_n_q;
   assign fail           = fail_q;
   assign retry_cnt      = retry_cnt_q;

endmodule

// File: tb/tb_pll_mode_ctrl.sv
// Directed bench for pll_mode_ctrl: power-up, glitchy lock, mode switch, timeout/fail,
// lock loss, bad mode and asynchronous reset, with hand-computed expectations.
module tb_pll_mode_ctrl;

   localparam logic [53:0] TBL = {18'h3F0C1, 18'h12345, 18'h0A5F3};

   logic       clkin = 1'b0;
   logic       rst_n;
   logic [1:0] mode_req;
   logic       mode_req_valid;
   logic       mode_req_ready;
   logic       bad_mode;
   logic       pll_lock;
   logic       pll_reset;
   logic [5:0] idsel, fbdsel, odsel;
   logic [1:0] cur_mode;
   logic       locked;
   logic       pix_rst_n;
   logic       fail;
   logic [1:0] retry_cnt;

   int checks = 0;
   int errors = 0;
   int n;
   logic seen;

   pll_mode_ctrl #(
      .NUM_MODES(3), .MODE_W(2), .MODE_TABLE(TBL), .INIT_MODE(0),
      .RESET_HOLD_CYCLES(4), .LOCK_STABLE_CYCLES(8),
      .LOCK_TIMEOUT_CYCLES(64), .MAX_RETRY(3)
   ) dut (
      .clkin(clkin), .rst_n(rst_n), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
      .mode_req_ready(mode_req_ready), .bad_mode(bad_mode), .pll_lock(pll_lock),
      .pll_reset(pll_reset), .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel),
      .cur_mode(cur_mode), .locked(locked), .pix_rst_n(pix_rst_n), .fail(fail),
      .retry_cnt(retry_cnt)
   );

   always #5 clkin = ~clkin;

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_codes(input string tag, input logic [5:0] ei, input logic [5:0] ef,
                            input logic [5:0] eo);
      chk({tag, "_idsel"}, 32'(idsel), 32'(ei));
      chk({tag, "_fbdsel"}, 32'(fbdsel), 32'(ef));
      chk({tag, "_odsel"}, 32'(odsel), 32'(eo));
   endtask

   initial begin
      rst_n = 1'b0; pll_lock = 1'b0; mode_req = 2'd0; mode_req_valid = 1'b0;
      tick(); tick();
      chk("rst_pll_reset", 32'(pll_reset), 32'd1);
      chk("rst_cur_mode", 32'(cur_mode), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_pix", 32'(pix_rst_n), 32'd0);
      chk("rst_fail", 32'(fail), 32'd0);
      chk("rst_ready", 32'(mode_req_ready), 32'd0);
      chk("rst_bad", 32'(bad_mode), 32'd0);
      chk("rst_retry", 32'(retry_cnt), 32'd0);
      chk_codes("rst", 6'h0A, 6'h17, 6'h33);

      // Power-up: 4-cycle reset pulse, lock 10 cycles later, locked 10 cycles after that.
      rst_n = 1'b1;
      n = 0;
      while (pll_reset !== 1'b0 && n < 50) begin tick(); n++; end
      chk("pu_pulse", n, 32'd4);
      repeat (10) tick();
      pll_lock = 1'b1;
      n = 0;
      while (locked !== 1'b1 && n < 50) begin tick(); n++; end
      chk("pu_lock_lat", n, 32'd10);
      chk("pu_pix", 32'(pix_rst_n), 32'd1);
      chk("pu_ready", 32'(mode_req_ready), 32'd1);
      chk_codes("pu", 6'h0A, 6'h17, 6'h33);

      // Lock loss in RUN: locked drops after sync + 1, no PLL reset pulse.
      pll_lock = 1'b0;
      n = 0; seen = 1'b0;
      while (locked !== 1'b0 && n < 20) begin tick(); n++; if (pll_reset) seen = 1'b1; end
      chk("loss_lat", n, 32'd3);
      chk("loss_pix", 32'(pix_rst_n), 32'd0);
      chk("loss_no_reset", 32'(seen), 32'd0);
      chk("loss_ready", 32'(mode_req_ready), 32'd0);
      chk("loss_retry", 32'(retry_cnt), 32'd0);

      // Glitchy lock: 5 high, 1 low, then high; stable count restarts.
      pll_lock = 1'b1;
      repeat (5) tick();
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      n = 0; seen = 1'b0;
      while (locked !== 1'b1 && n < 50) begin tick(); n++; if (pll_reset) seen = 1'b1; end
      chk("glitch_lat", n, 32'd10);
      chk("glitch_no_reset", 32'(seen), 32'd0);
      chk("glitch_pix", 32'(pix_rst_n), 32'd1);

      // Mode switch to mode 2.
      chk("sw_ready_before", 32'(mode_req_ready), 32'd1);
      pll_lock = 1'b0; mode_req = 2'd2; mode_req_valid = 1'b1;
      tick();
      mode_req_valid = 1'b0;
      chk("sw_ready", 32'(mode_req_ready), 32'd0);
      chk("sw_cur_mode", 32'(cur_mode), 32'd2);
      chk("sw_pll_reset", 32'(pll_reset), 32'd1);
      chk("sw_locked", 32'(locked), 32'd0);
      chk_codes("sw", 6'h3F, 6'h03, 6'h01);
      n = 0;
      while (pll_reset !== 1'b0 && n < 50) begin tick(); n++; end
      chk("sw_pulse", n, 32'd4);
      repeat (3) tick();
      pll_lock = 1'b1;
      n = 0;
      while (locked !== 1'b1 && n < 50) begin tick(); n++; end
      chk("sw_lock_lat", n, 32'd10);
      chk("sw_cur_mode_run", 32'(cur_mode), 32'd2);
      chk_codes("sw_run", 6'h3F, 6'h03, 6'h01);

      // Out-of-range request: one-cycle bad_mode, nothing else changes.
      mode_req = 2'd3; mode_req_valid = 1'b1;
      tick();
      mode_req_valid = 1'b0;
      chk("bad_pulse", 32'(bad_mode), 32'd1);
      chk("bad_ready", 32'(mode_req_ready), 32'd1);
      chk("bad_locked", 32'(locked), 32'd1);
      chk("bad_cur_mode", 32'(cur_mode), 32'd2);
      chk("bad_pll_reset", 32'(pll_reset), 32'd0);
      chk_codes("bad", 6'h3F, 6'h03, 6'h01);
      tick();
      chk("bad_one_cycle", 32'(bad_mode), 32'd0);

      // Same-mode request arriving with a synchronised lock fall: request wins.
      pll_lock = 1'b0;
      tick(); tick();
      mode_req = 2'd2; mode_req_valid = 1'b1;
      tick();
      mode_req_valid = 1'b0;
      chk("win_pll_reset", 32'(pll_reset), 32'd1);
      chk("win_ready", 32'(mode_req_ready), 32'd0);
      chk("win_cur_mode", 32'(cur_mode), 32'd2);

      // Lock never arrives: three attempts, then FAIL.
      for (int a = 1; a <= 3; a++) begin
         n = 0;
         while (pll_reset !== 1'b0 && n < 50) begin tick(); n++; end
         chk($sformatf("tmo_pulse%0d", a), n, 32'd4);
         n = 0; seen = 1'b0;
         while (32'(retry_cnt) != a && n < 200) begin
            tick(); n++;
            if (pll_reset && 32'(retry_cnt) != a) seen = 1'b1;
         end
         chk($sformatf("tmo_wait%0d", a), n, 32'd64);
         chk($sformatf("tmo_reset_low%0d", a), 32'(seen), 32'd0);
         chk($sformatf("tmo_pll_reset%0d", a), 32'(pll_reset), (a < 3) ? 32'd1 : 32'd0);
      end
      chk("fail_flag", 32'(fail), 32'd1);
      chk("fail_ready", 32'(mode_req_ready), 32'd1);
      chk("fail_locked", 32'(locked), 32'd0);
      chk("fail_pix", 32'(pix_rst_n), 32'd0);
      repeat (5) tick();
      chk("fail_stays", 32'(fail), 32'd1);

      // Request for mode 1 clears the failure.
      mode_req = 2'd1; mode_req_valid = 1'b1;
      tick();
      mode_req_valid = 1'b0;
      chk("rec_fail", 32'(fail), 32'd0);
      chk("rec_retry", 32'(retry_cnt), 32'd0);
      chk("rec_cur_mode", 32'(cur_mode), 32'd1);
      chk("rec_pll_reset", 32'(pll_reset), 32'd1);
      chk_codes("rec", 6'h12, 6'h0D, 6'h05);

      // Asynchronous reset mid-WAIT_LOCK.
      n = 0;
      while (pll_reset !== 1'b0 && n < 50) begin tick(); n++; end
      chk("rec_pulse", n, 32'd4);
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_pll_reset", 32'(pll_reset), 32'd1);
      chk("arst_cur_mode", 32'(cur_mode), 32'd0);
      chk("arst_ready", 32'(mode_req_ready), 32'd0);
      chk_codes("arst", 6'h0A, 6'h17, 6'h33);
      tick();
      rst_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pll_mode_ctrl.md
Name: pll_mode_ctrl

Overview:
Run-time supervisor for a Gowin PLLVR whose IDSEL/FBDSEL/ODSEL dynamic divider inputs are enabled. It holds a parametrised table of video clock modes, drives the divider select codes, sequences PLL reset and lock qualification, and retries when lock does not arrive. Only after the PLL has held a stable lock does it release the downstream pixel/TMDS reset. It sits between the 27 MHz board clock domain and the TMDS PLL, replacing fixed single-mode PLL wrappers when a design needs several selectable resolutions.

Parameters:
NUM_MODES, 4, number of table entries (1..16)
MODE_W, 2, width of the mode index; must be at least clog2(NUM_MODES)
MODE_TABLE, {NUM_MODES{18'h0}}, packed table; entry i occupies bits [18*i+17:18*i] as {idsel[5:0], fbdsel[5:0], odsel[5:0]} raw PLL codes
INIT_MODE, 0, mode loaded at reset
RESET_HOLD_CYCLES, 16, clkin cycles pll_reset is held high per attempt (>=2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised lock-high cycles required
LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before retry
MAX_RETRY, 3, failed attempts allowed before FAIL

Ports:
clkin  in  1  27 MHz reference clock; the only clock
rst_n  in  1  asynchronous active-low reset
mode_req  in  MODE_W  requested mode index
mode_req_valid  in  1  request strobe
mode_req_ready  out  1  high when a request can be accepted
bad_mode  out  1  one-cycle pulse when a request is out of range
pll_lock  in  1  PLL LOCK, asynchronous to clkin
pll_reset  out  1  to PLLVR RESET
idsel  out  6  to PLLVR IDSEL
fbdsel  out  6  to PLLVR FBDSEL
odsel  out  6  to PLLVR ODSEL
cur_mode  out  MODE_W  mode currently programmed
locked  out  1  qualified stable lock
pix_rst_n  out  1  downstream active-low reset
fail  out  1  retries exhausted
retry_cnt  out  2  failed attempts for the current mode, saturating at 3

Behaviour:
- pll_lock passes through a 2-FF synchroniser (lock_s) before it is used anywhere.
- Reset values:
  - state = HOLD, pll_reset = 1.
  - idsel/fbdsel/odsel = table[INIT_MODE], cur_mode = INIT_MODE.
  - locked = 0, pix_rst_n = 0, fail = 0, mode_req_ready = 0, bad_mode = 0, retry_cnt = 0.
  - All counters = 0.
- All outputs are registered.
- HOLD:
  - pll_reset = 1; count RESET_HOLD_CYCLES.
  - Then pll_reset = 0 and go to WAIT_LOCK with both the stable and timeout counters cleared.
- WAIT_LOCK:
  - Timeout counter increments every cycle.
  - Stable counter increments while lock_s = 1 and clears to 0 on any cycle with lock_s = 0.
  - Stable counter reaching LOCK_STABLE_CYCLES, go to RUN. Register locked = 1 and pix_rst_n = 1 on the transition.
  - Timeout counter reaching LOCK_TIMEOUT_CYCLES first: retry_cnt increments.
    - Go to FAIL if the new count equals MAX_RETRY.
    - Otherwise go to HOLD.
  - If both conditions hit in the same cycle, lock wins.
- RUN:
  - If lock_s falls: locked = 0 and pix_rst_n = 0 on the next edge. Go to WAIT_LOCK without pulsing pll_reset. retry_cnt is unchanged.
- FAIL:
  - fail = 1, pll_reset = 0, locked = 0, pix_rst_n = 0.
  - Exit only on an accepted request or rst_n.
- Mode requests:
  - mode_req_ready = 1 only in RUN and FAIL.
  - Handshake occurs on valid & ready in the same cycle.
  - In-range request, on the next edge:
    - Load the divider codes and cur_mode.
    - Set locked = 0, pix_rst_n = 0, fail = 0, retry_cnt = 0.
    - Go to HOLD.
  - A request for the current mode is still honoured (full relock).
  - Request >= NUM_MODES:
    - Consumed.
    - bad_mode pulses for one cycle.
    - State, codes and outputs are otherwise unchanged.
  - Requests while ready = 0 are ignored; no queueing.
  - A request in the same cycle that lock_s falls in RUN: the request wins.
- Divider codes change only on entry to HOLD, so they never change while pll_reset = 0.
- Counters are sized as clog2(max parameter) + 1 and never wrap.
- Asserting rst_n low mid-sequence forces reset values immediately, including pll_reset = 1. The programmed mode returns to INIT_MODE.

Test Plan:
Bench parameters: NUM_MODES=3, RESET_HOLD_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, MAX_RETRY=3, INIT_MODE=0, table[0]=18'h0A5F3.
- Power-up: release rst_n; model lock rising 10 cycles after pll_reset falls -> pll_reset high exactly 4 cycles; locked and pix_rst_n rise 8 cycles plus 2 sync cycles after lock; codes equal table[0].
- Glitchy lock: lock high 5 cycles, low 1, then high -> stable count restarts; locked asserts only after 8 consecutive synchronised highs.
- Mode switch: in RUN, request mode 2 -> ready drops; codes equal table[2] next edge; pll_reset pulses 4 cycles; relock to RUN; cur_mode = 2.
- Timeout: lock never rises -> three 4-cycle pll_reset pulses spaced by 64-cycle waits; retry_cnt goes 1, 2, 3; fail = 1. A request for mode 1 then clears fail and retry_cnt.
- Lock loss: drop lock in RUN -> locked/pix_rst_n low within 3 cycles with no pll_reset pulse; lock returning gives RUN again after 8 stable cycles.
- Bad mode and reset: request mode 3 -> bad_mode pulses 1 cycle, state unchanged. Assert rst_n mid-WAIT_LOCK -> pll_reset = 1 and codes = table[0] immediately.
